host_cfg_arbiter: RTL

//  Owns the host-interface configuration register bank: host_mode, IO config, UART config and baud_nco.

---
 rtl/host_cfg_arbiter.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/host_cfg_arbiter.sv
// Host-interface configuration register bank shared by two requesters under
// round-robin arbitration; host_mode writes wait for the host interface to idle.
module host_cfg_arbiter #(
  parameter logic [1:0]  DEF_HOST_MODE = 2'b00,
  parameter logic [31:0] DEF_BAUD_NCO  = 32'h0000_0000,
  parameter logic [7:0]  VERSION_VALUE = 8'h10,
  parameter int unsigned MODE_TIMEOUT  = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [7:0]  a_addr,
  input  logic [7:0]  a_wdata,
  output logic        a_ack,
  output logic [7:0]  a_rdata,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [7:0]  b_addr,
  input  logic [7:0]  b_wdata,
  output logic        b_ack,
  output logic [7:0]  b_rdata,
  input  logic        host_idle,
  output logic [1:0]  host_mode,
  output logic        inactive_io,
  output logic        unused_io,
  output logic        miso_edge,
  output logic [3:0]  stop_bit,
  output logic        flow_control,
  output logic [31:0] baud_nco,
  output logic        mode_change,
  output logic        mode_forced,
  output logic        busy
);
  localparam int unsigned CW = $clog2(MODE_TIMEOUT);

  typedef enum logic [1:0] {IDLE, ACCESS, MODE_WAIT, ACK} state_t;

  state_t        state_q, state_d;
  logic          gnt_b_q, gnt_b_d;
  logic          last_b_q, last_b_d;
  logic          we_q, we_d;
  logic [7:0]    addr_q, addr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic [1:0]    pend_q, pend_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    mode_q, mode_d;
  logic [2:0]    io_q, io_d;
  logic [4:0]    uart_q, uart_d;
  logic [31:0]   shadow_q, shadow_d;
  logic [31:0]   baud_q, baud_d;
  logic [7:0]    rdata_q, rdata_d;
  logic          chg_q, chg_d;
  logic          frc_q, frc_d;
  logic [7:0]    rd_mux;
  logic          pick_b;

  always_comb begin
    rd_mux = '0;
    case (addr_q)
      8'h00:   rd_mux = VERSION_VALUE;
      8'h01:   rd_mux = {6'b0, mode_q};
      8'h02:   rd_mux = {5'b0, io_q};
      8'h03:   rd_mux = {3'b0, uart_q};
      8'h04:   rd_mux = baud_q[7:0];
      8'h05:   rd_mux = baud_q[15:8];
      8'h06:   rd_mux = baud_q[23:16];
      8'h07:   rd_mux = baud_q[31:24];
      default: rd_mux = '0;
    endcase
  end

  // With both requesting, last_b_q selects the port that was not served last.
  assign pick_b = b_req && (!a_req || !last_b_q);

  always_comb begin
    state_d  = state_q;
    gnt_b_d  = gnt_b_q;
    last_b_d = last_b_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    pend_d   = pend_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    io_d     = io_q;
    uart_d   = uart_q;
    shadow_d = shadow_q;
    baud_d   = baud_q;
    rdata_d  = rdata_q;
    chg_d    = 1'b0;
    frc_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (a_req || b_req) begin
          gnt_b_d  = pick_b;
          last_b_d = pick_b;
          we_d     = pick_b ? b_we    : a_we;
          addr_d   = pick_b ? b_addr  : a_addr;
          wdata_d  = pick_b ? b_wdata : a_wdata;
          state_d  = ACCESS;
        end
      end
      ACCESS: begin
        rdata_d = we_q ? '0 : rd_mux;
        state_d = ACK;
        if (we_q) begin
          case (addr_q)
            8'h01: begin
              pend_d  = wdata_q[1:0];
              cnt_d   = '0;
              state_d = MODE_WAIT;
            end
            8'h02: io_d   = wdata_q[2:0];
            8'h03: uart_d = wdata_q[4:0];
            8'h04: shadow_d[7:0]   = wdata_q;
            8'h05: shadow_d[15:8]  = wdata_q;
            8'h06: shadow_d[23:16] = wdata_q;
            8'h07: begin
              shadow_d[31:24] = wdata_q;
              baud_d          = {wdata_q, shadow_q[23:0]};
            end
            default: ;
          endcase
        end
      end
      MODE_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (host_idle) begin
          mode_d  = pend_q;
          chg_d   = 1'b1;
          state_d = ACK;
        end else if (cnt_q == CW'(MODE_TIMEOUT - 1)) begin
          mode_d  = pend_q;
          chg_d   = 1'b1;
          frc_d   = 1'b1;
          state_d = ACK;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      gnt_b_q  <= 1'b0;
      last_b_q <= 1'b1;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      pend_q   <= '0;
      cnt_q    <= '0;
      mode_q   <= DEF_HOST_MODE;
      io_q     <= '0;
      uart_q   <= '0;
      shadow_q <= DEF_BAUD_NCO;
      baud_q   <= DEF_BAUD_NCO;
      rdata_q  <= '0;
      chg_q    <= 1'b0;
      frc_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_b_q  <= gnt_b_d;
      last_b_q <= last_b_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      pend_q   <= pend_d;
      cnt_q    <= cnt_d;
      mode_q   <= mode_d;
      io_q     <= io_d;
      uart_q   <= uart_d;
      shadow_q <= shadow_d;
      baud_q   <= baud_d;
      rdata_q  <= rdata_d;
      chg_q    <= chg_d;
      frc_q    <= frc_d;
    end
  end

  assign a_ack        = (state_q == ACK) && !gnt_b_q;
  assign b_ack        = (state_q == ACK) &&  gnt_b_q;
  assign a_rdata      = a_ack ? rdata_q : '0;
  assign b_rdata      = b_ack ? rdata_q : '0;
  assign host_mode    = mode_q;
  assign inactive_io  = io_q[0];
  assign unused_io    = io_q[1];
  assign miso_edge    = io_q[2];
  assign stop_bit     = uart_q[3:0];
  assign flow_control = uart_q[4];
  assign baud_nco     = baud_q;
  assign mode_change  = chg_q;
  assign mode_forced  = frc_q;
  assign busy         = (state_q != IDLE);
endmodule
